image_unload: RTL and testbench

IMAGE_UNLOAD -- requirements
Module: image_unload

---
 rtl/image_unload.sv | 151 +++++++++++++++
 tb/tb_image_unload.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_unload.sv
`timescale 1ns/1ps
// Bit-serial image unloader: reads N_BITS bits from a FIFO into a shadow
// register and commits them to the process image, with timeout and abort.
module image_unload #(
    parameter int N_BITS = 16,
    parameter int TMO    = 8
) (
    input  logic        clk_i,
    input  logic        clr_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        fifo_empty_i,
    input  logic        fifo_din_i,
    output logic        fifo_rd_o,
    output logic        fifo_en_o,
    output logic [15:0] out_img_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [4:0] NB = 5'(N_BITS);
    localparam logic [7:0] TM = 8'(TMO);

    state_t      state_q, state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] out_q, out_d;
    logic [4:0]  iss_q, iss_d;
    logic [4:0]  cap_q, cap_d;
    logic        pend_q, pend_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        und_q, und_d;
    logic        rd;
    logic        done;
    logic        rst_n_q;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            rst_n_q <= 1'b0;
        end else begin
            rst_n_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            out_q    <= '0;
            iss_q    <= '0;
            cap_q    <= '0;
            pend_q   <= 1'b0;
            tmo_q    <= '0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            iss_q    <= iss_d;
            cap_q    <= cap_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
            und_q    <= und_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        iss_d    = iss_q;
        cap_d    = cap_q;
        pend_d   = 1'b0;
        tmo_d    = tmo_q;
        und_d    = und_q;
        done     = 1'b0;
        rd       = (state_q == READ) && !fifo_empty_i && (iss_q < NB);

        // Capture of the previous cycle's read overlaps the next issue.
        if (pend_q) begin
            shadow_d[cap_q[3:0]] = fifo_din_i;
            cap_d                = cap_q + 5'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = READ;
                    shadow_d = '0;
                    iss_d    = '0;
                    cap_d    = '0;
                    tmo_d    = '0;
                    und_d    = 1'b0;
                end
            end
            READ: begin
                if (rd) begin
                    iss_d  = iss_q + 5'd1;
                    pend_d = 1'b1;
                    tmo_d  = '0;
                    if (iss_q + 5'd1 == NB) begin
                        state_d = DRAIN;
                    end
                end else if (fifo_empty_i && (iss_q < NB)) begin
                    if (tmo_q + 8'd1 == TM) begin
                        und_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                out_d   = shadow_q;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a pending commit.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            out_d   = out_q;
            und_d   = und_q;
            pend_d  = 1'b0;
            done    = 1'b0;
        end
    end

    assign fifo_rd_o  = rd;
    assign fifo_en_o  = rd;
    assign out_img_o  = out_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done;
    assign underrun_o = und_q;

endmodule

// File: tb/tb_image_unload.sv
`timescale 1ns/1ps
// Directed bench for image_unload: a 16-bit and a 4-bit instance share
// one bit FIFO model; expected images and cycle counts are hand-computed.
module tb_image_unload;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic        fifo_empty;
    logic        fifo_din = 1'b0;
    logic        rd_a, en_a, busy_a, done_a, und_a;
    logic        rd_b, en_b, busy_b, done_b, und_b;
    logic [15:0] img_a, img_b;

    logic        mem [0:255];
    int          wp = 0;
    int          rp = 0;

    int total = 0;
    int bad   = 0;
    int na_rd = 0, nb_rd = 0, na_done = 0, nb_done = 0;

    image_unload #(.N_BITS(16), .TMO(8)) u16 (
        .clk_i(clk), .clr_n_i(clr_n), .start_i(start_a), .abort_i(abort_a),
        .fifo_empty_i(fifo_empty), .fifo_din_i(fifo_din),
        .fifo_rd_o(rd_a), .fifo_en_o(en_a), .out_img_o(img_a),
        .busy_o(busy_a), .done_o(done_a), .underrun_o(und_a)
    );

    image_unload #(.N_BITS(4), .TMO(8)) u4 (
        .clk_i(clk), .clr_n_i(clr_n), .start_i(start_b), .abort_i(abort_b),
        .fifo_empty_i(fifo_empty), .fifo_din_i(fifo_din),
        .fifo_rd_o(rd_b), .fifo_en_o(en_b), .out_img_o(img_b),
        .busy_o(busy_b), .done_o(done_b), .underrun_o(und_b)
    );

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if ((rd_a || rd_b) && (wp != rp)) begin
            fifo_din <= mem[rp];
            rp       <= rp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rd_a)   na_rd++;
        if (rd_b)   nb_rd++;
        if (done_a) na_done++;
        if (done_b) nb_done++;
    endtask

    task automatic push(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            mem[wp] = v[k];
            wp      = wp + 1;
        end
    endtask

    task automatic run_a(output int lat);
        lat     = -1;
        start_a = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) start_a = 1'b0;
            if (done_a) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat, first, last, stalls, rd0, dn0;

    initial begin
        clr_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;

        // Reset state, with the first scan preloaded
        push(32'h0000_0F0D, 16);
        repeat (3) tick();
        check("rst_img", 32'(img_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_und", 32'(und_a), 32'h0);
        check("rst_rd", 32'(rd_a), 32'h0);
        check("rst_en", 32'(en_a), 32'h0);

        // START on the first edge after release is not honoured
        clr_n   = 1'b1;
        start_a = 1'b1;
        tick();
        check("rel_first_edge", 32'(busy_a), 32'h0);

        // Full 16-bit scan, START held for the second edge
        na_rd = 0;
        first = -1;
        last  = -1;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) start_a = 1'b0;
            if (rd_a) begin
                if (first < 0) first = i;
                last = i;
            end
            if (done_a) begin
                lat = i;
                break;
            end
        end
        check("full_lat", 32'(lat), 32'd18);
        check("full_rd_first", 32'(first), 32'd1);
        check("full_rd_last", 32'(last), 32'd16);
        check("full_rd_cnt", 32'(na_rd), 32'd16);
        tick();
        check("full_img", 32'(img_a), 32'h0F0D);
        check("full_idle", 32'(busy_a), 32'h0);

        // Writer gap of 4 cycles after 5 bits
        push(32'h0000_A5C3, 5);
        start_a = 1'b1;
        stalls  = 0;
        lat     = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) start_a = 1'b0;
            if (i >= 6 && i <= 9 && !rd_a) stalls++;
            if (i == 10) push(32'h0000_A5C3 >> 5, 11);
            if (done_a) begin
                lat = i;
                break;
            end
        end
        check("gap_stalls", 32'(stalls), 32'd4);
        check("gap_lat", 32'(lat), 32'd22);
        check("gap_und", 32'(und_a), 32'h0);
        tick();
        check("gap_img", 32'(img_a), 32'hA5C3);

        // Underrun: 3 bits only
        dn0     = na_done;
        push(32'h5, 3);
        start_a = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 1) start_a = 1'b0;
        end
        check("und_early", 32'(und_a), 32'h0);
        tick();
        check("und_set", 32'(und_a), 32'h1);
        check("und_idle", 32'(busy_a), 32'h0);
        check("und_img", 32'(img_a), 32'hA5C3);
        check("und_nodone", 32'(na_done - dn0), 32'd0);

        // Abort in the cycle issuing the 7th read
        push(32'h1234_5678, 23);
        rd0     = na_rd;
        dn0     = na_done;
        start_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                start_a = 1'b0;
                check("start_clr_und", 32'(und_a), 32'h0);
            end
            if (i == 7) abort_a = 1'b1;
        end
        abort_a = 1'b0;
        check("abt_idle", 32'(busy_a), 32'h0);
        check("abt_reads", 32'(na_rd - rd0), 32'd7);
        check("abt_img", 32'(img_a), 32'hA5C3);
        check("abt_nodone", 32'(na_done - dn0), 32'd0);
        run_a(lat);
        check("abt_next_lat", 32'(lat), 32'd18);
        tick();
        check("abt_next_img", 32'(img_a), 32'h68AC);

        // Reset pulse during DRAIN
        push(32'h0000_3C5A, 16);
        dn0     = na_done;
        start_a = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) start_a = 1'b0;
        end
        check("drain_busy", 32'(busy_a), 32'h1);
        check("drain_rd", 32'(rd_a), 32'h0);
        clr_n = 1'b0;
        #1;
        check("clr_img", 32'(img_a), 32'h0);
        check("clr_busy", 32'(busy_a), 32'h0);
        check("clr_done", 32'(done_a), 32'h0);
        check("clr_rd", 32'(rd_a), 32'h0);
        check("clr_en", 32'(en_a), 32'h0);
        tick();
        tick();
        clr_n = 1'b1;
        tick();
        tick();
        check("clr_nodone", 32'(na_done - dn0), 32'd0);
        push(32'h0000_9E61, 16);
        run_a(lat);
        check("post_clr_lat", 32'(lat), 32'd18);
        tick();
        check("post_clr_img", 32'(img_a), 32'h9E61);

        // 4-bit instance, second START while busy
        push(32'hB, 4);
        push(32'hF, 4);
        nb_rd   = 0;
        lat     = -1;
        start_b = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) start_b = 1'b0;
            if (i == 2) start_b = 1'b1;
            if (i == 3) start_b = 1'b0;
            if (done_b) begin
                lat = i;
                break;
            end
        end
        check("n4_lat", 32'(lat), 32'd6);
        tick();
        check("n4_img", 32'(img_b), 32'h000B);
        repeat (8) tick();
        check("n4_idle", 32'(busy_b), 32'h0);
        check("n4_reads", 32'(nb_rd), 32'd4);
        check("n4_en", 32'(en_b), 32'h0);
        check("n4_und", 32'(und_b), 32'h0);
        check("n4_img_hold", 32'(img_b), 32'h000B);
        check("n16_img_hold", 32'(img_a), 32'h9E61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
